// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and sprite scheduler state encoding
package vga_pkg;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} sched_state_t;
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: one-axis bounce arithmetic shared by the scheduler for X and Y
module sprite_axis_step #(
  parameter int STEP_W = 4
) (
  input  logic [9:0]        pos,
  input  logic              dir,
  input  logic [STEP_W-1:0] speed,
  input  logic [9:0]        max,
  output logic [9:0]        pos_next,
  output logic              dir_next,
  output logic              hit
);
  logic [10:0] sum;
  logic        up_hit;
  logic        dn_hit;
  logic        moving;
  always_comb begin
    sum      = {1'b0, pos} + 11'(speed);
    up_hit   = sum >= {1'b0, max};
    dn_hit   = pos <= 10'(speed);
    moving   = speed != '0;
    hit      = moving && (dir ? up_hit : dn_hit);
    pos_next = !moving ? pos : dir ? (up_hit ? max : sum[9:0]) : (dn_hit ? 10'd0 : pos - 10'(speed));
    dir_next = hit ? ~dir : dir;
  end
endmodule

// File: rtl/vga_sprite_scheduler.sv
// vga_sprite_scheduler: frame-synchronous sprite motion, X then Y through one shared
// axis calculator, committed together at the start of vertical blanking
module vga_sprite_scheduler import vga_pkg::*; #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SPRITE_SIZE = 54,
  parameter int STEP_W      = 4,
  parameter int DIV_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              run,
  input  logic              step,
  input  logic [DIV_W-1:0]  frame_div,
  input  logic [STEP_W-1:0] speed_x,
  input  logic [STEP_W-1:0] speed_y,
  output logic [9:0]        sprite_x,
  output logic [9:0]        sprite_y,
  output logic              dir_x,
  output logic              dir_y,
  output logic              bounce,
  output logic              frame_tick
);
  localparam logic [9:0] X_MAX = 10'(H_RES - SPRITE_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_RES - SPRITE_SIZE);
  sched_state_t      state;
  logic [DIV_W-1:0]  frame_cnt;
  logic              step_pend;
  logic [9:0]        wx, wy;
  logic              wdx, wdy, whx, why;
  logic              due, trigger, on_x;
  logic [9:0]        a_pos, a_max, n_pos;
  logic              a_dir, n_dir, n_hit;
  logic [STEP_W-1:0] a_speed;
  always_comb begin
    due     = frame_cnt == frame_div;
    trigger = frame_tick && state == IDLE && (run ? due : step_pend);
    on_x    = state == CALC_X;
    a_pos   = on_x ? sprite_x : sprite_y;
    a_dir   = on_x ? dir_x : dir_y;
    a_speed = on_x ? speed_x : speed_y;
    a_max   = on_x ? X_MAX : Y_MAX;
  end
  sprite_axis_step #(.STEP_W(STEP_W)) u_axis (
    .pos(a_pos), .dir(a_dir), .speed(a_speed), .max(a_max),
    .pos_next(n_pos), .dir_next(n_dir), .hit(n_hit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      step_pend  <= 1'b0;
      frame_tick <= 1'b0;
      bounce     <= 1'b0;
      sprite_x   <= '0;
      sprite_y   <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      {wx, wdx, whx} <= '0;
      {wy, wdy, why} <= '0;
    end else begin
      frame_tick <= counter_x == 10'd0 && counter_y == 10'(V_RES);
      if (frame_tick) frame_cnt <= due ? '0 : frame_cnt + DIV_W'(1);
      // a step landing on the tick cycle stays pending for the following tick
      step_pend <= run ? 1'b0 : step ? 1'b1 : trigger ? 1'b0 : step_pend;
      state <= trigger ? CALC_X : state == CALC_X ? CALC_Y : state == CALC_Y ? COMMIT : IDLE;
      bounce <= 1'b0;
      if (state == CALC_X) {wx, wdx, whx} <= {n_pos, n_dir, n_hit};
      if (state == CALC_Y) {wy, wdy, why} <= {n_pos, n_dir, n_hit};
      if (state == COMMIT) begin
        sprite_x <= wx;
        sprite_y <= wy;
        dir_x    <= wdx;
        dir_y    <= wdy;
        bounce   <= whx | why;
      end
    end
  end
endmodule

// File: tb/tb_vga_sprite_scheduler.sv
// tb_vga_sprite_scheduler: randomized scoreboard bench with a frame-level motion model
module tb_vga_sprite_scheduler;
  localparam int XM = 586;
  localparam int YM = 426;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [9:0] counter_x = 10'd5, counter_y = 10'd5;
  logic       run = 0, step = 0;
  logic [7:0] frame_div = 0;
  logic [3:0] speed_x = 0, speed_y = 0;
  logic [9:0] sprite_x, sprite_y;
  logic       dir_x, dir_y, bounce, frame_tick;
  int pass_cnt = 0, total_cnt = 0;
  bit mon_en = 1;
  int mx = 0, my = 0, mdx = 1, mdy = 1, mcnt = 0, mpend = 0;
  typedef struct {int x0, y0, dx0, dy0, x, y, dx, dy, b;} exp_t;
  exp_t q[$];

  vga_sprite_scheduler dut (
    .clk(clk), .rst_n(rst_n), .counter_x(counter_x), .counter_y(counter_y),
    .run(run), .step(step), .frame_div(frame_div), .speed_x(speed_x), .speed_y(speed_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .dir_x(dir_x), .dir_y(dir_y),
    .bounce(bounce), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total_cnt++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  function automatic void axis(input int p, input int d, input int s, input int m,
                               output int np, output int nd, output int h);
    np = p; nd = d; h = 0;
    if (s != 0 && d == 1 && p + s >= m) begin np = m; nd = 0; h = 1; end
    else if (s != 0 && d == 1) np = p + s;
    else if (s != 0 && p <= s) begin np = 0; nd = 1; h = 1; end
    else if (s != 0) np = p - s;
  endfunction

  task automatic model_tick();
    exp_t e;
    int due, trig, hx, hy;
    e.x0 = mx; e.y0 = my; e.dx0 = mdx; e.dy0 = mdy;
    due = (mcnt == int'(frame_div));
    mcnt = due ? 0 : (mcnt + 1) % 256;
    if (run) mpend = 0;
    trig = run ? due : mpend;
    if (trig && !run) mpend = 0;
    hx = 0; hy = 0;
    if (trig) begin
      axis(mx, mdx, int'(speed_x), XM, mx, mdx, hx);
      axis(my, mdy, int'(speed_y), YM, my, mdy, hy);
    end
    e.x = mx; e.y = my; e.dx = mdx; e.dy = mdy; e.b = hx | hy;
    q.push_back(e);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mdx = 1; mdy = 1; mcnt = 0; mpend = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rand_counters();
    counter_x = 10'($urandom_range(0, 799));
    counter_y = 10'($urandom_range(0, 524));
    if (counter_x == 0 && counter_y == 480) counter_x = 10'd1;
  endtask

  task automatic frame(input bit do_step);
    cyc();
    step = 0;
    counter_x = 0; counter_y = 10'd480;
    if (mon_en) model_tick();
    for (int i = 1; i < 16; i++) begin
      cyc();
      if (i == 1) begin counter_x = 10'd1; counter_y = 10'd480; end
      else if (i == 2) begin counter_x = 10'd0; counter_y = 10'd479; end
      else rand_counters();
      step = (i == 8) && do_step;
      if (step && !run) mpend = 1;
    end
    cyc();
    step = 0;
    rand_counters();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(0);
  endtask

  task automatic reset_mid_update();
    mon_en = 0;
    cyc(); counter_x = 0; counter_y = 10'd480;
    cyc(); counter_x = 10'd5; counter_y = 10'd5;
    cyc();
    cyc();
    #2 rst_n = 0;
    #1;
    chk("rstmid_x", int'(sprite_x), 0);
    chk("rstmid_y", int'(sprite_y), 0);
    chk("rstmid_dx", int'(dir_x), 1);
    chk("rstmid_dy", int'(dir_y), 1);
    chk("rstmid_bounce", int'(bounce), 0);
    repeat (3) cyc();
    rst_n = 1;
    model_reset();
    mon_en = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && frame_tick) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          e = q.pop_front();
          @(negedge clk);
          chk("tick_width", int'(frame_tick), 0);
          @(negedge clk);
          @(negedge clk);
          chk("early_x", int'(sprite_x), e.x0);
          chk("early_y", int'(sprite_y), e.y0);
          chk("early_dx", int'(dir_x), e.dx0);
          chk("early_dy", int'(dir_y), e.dy0);
          @(negedge clk);
          chk("x", int'(sprite_x), e.x);
          chk("y", int'(sprite_y), e.y);
          chk("dir_x", int'(dir_x), e.dx);
          chk("dir_y", int'(dir_y), e.dy);
          chk("bounce", int'(bounce), e.b);
          @(negedge clk);
          chk("bounce_width", int'(bounce), 0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(sprite_x), 0);
    chk("rst_y", int'(sprite_y), 0);
    chk("rst_dx", int'(dir_x), 1);
    chk("rst_dy", int'(dir_y), 1);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_tick", int'(frame_tick), 0);
    rst_n = 1;
    frames(3);
    run = 1; frame_div = 0; speed_x = 4'd3; speed_y = 4'd2;
    frames(10);
    chk("basic_x30", int'(sprite_x), 30);
    chk("basic_y20", int'(sprite_y), 20);
    reset_mid_update();
    speed_x = 4'd15; speed_y = 4'd15;
    frames(28);
    chk("wall_y420", int'(sprite_y), 420);
    frame(0);
    chk("wall_y426", int'(sprite_y), 426);
    chk("wall_dy0", int'(dir_y), 0);
    frame(0);
    chk("wall_y411", int'(sprite_y), 411);
    frames(9);
    chk("wall_x585", int'(sprite_x), 585);
    frame(0);
    chk("wall_x586", int'(sprite_x), 586);
    chk("wall_dx0", int'(dir_x), 0);
    speed_x = 0;
    frame(0);
    chk("hold_x586", int'(sprite_x), 586);
    chk("hold_dx0", int'(dir_x), 0);
    speed_x = 4'd15;
    frame(0);
    chk("wall_x571", int'(sprite_x), 571);
    frame_div = 8'd2; speed_x = 4'd1; speed_y = 4'd1;
    frames(9);
    run = 0; frame_div = 0;
    frame(1);
    frames(2);
    run = 1;
    frame(1);
    frame(0);
    for (int i = 0; i < 150; i++) begin
      run = ($urandom_range(0, 3) != 0);
      if (run) mpend = 0;
      frame_div = 8'($urandom_range(0, 3));
      speed_x = 4'($urandom_range(0, 15));
      speed_y = 4'($urandom_range(0, 15));
      frame(1'($urandom_range(0, 1)));
    end
    repeat (10) cyc();
    chk("queue_drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
